ccff_chain_loader: RTL and testbench

Host-side driver for the fabric configuration chain: accepts 32-bit configuration words over a valid/ready stream and shifts them bit-serially into the chain head `ccff_head`, one bit per enabled `prog_clk` edge. It generates the clock enable that gates the fabric `prog_clk`, so the chain never shifts without a valid bit. It samples the bits leaving the chain at `ccff_tail`, which lets the previous configuration be read back. It sits between the SoC configuration port and the first tile's `ccff_head`. The last tile's `ccff_tail` returns to it.

---
 rtl/ccff_chain_loader.sv | 159 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes 32-bit words over valid/ready, shifts them
// bit-serially into ccff_head with a registered prog_clk gate enable, and keeps
// CRC-16-CCITT signatures of the bits going in and the bits returning at ccff_tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 4000,
  parameter int CNT_W     = 16
) (
  input  logic        prog_clk,
  input  logic        prog_reset,
  input  logic        start,
  input  logic        abort,
  input  logic [0:31] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        ccff_head,
  output logic        cfg_clk_en,
  input  logic        ccff_tail,
  output logic        busy,
  output logic        done,
  output logic [0:15] crc_in,
  output logic [0:15] crc_out
);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       sr_cnt_q, sr_cnt_d;
  logic             hold_full_q, hold_full_d;
  logic [0:31]      sr_q, sr_d;
  logic [0:31]      hold_q, hold_d;
  logic [15:0]      crc_in_q, crc_in_d;
  logic [15:0]      crc_out_q, crc_out_d;
  logic             s_ready_d, head_d, en_d, busy_d, done_d;
  logic             fire, accept, sr_drain, last_bit;
  logic [CNT_W:0]   remaining;

  // One serial CRC-16-CCITT step (poly 0x1021, MSB-first, no reflection).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Next-state, buffer management and registered-output precomputation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_cnt_d    = sr_cnt_q;
    hold_full_d = hold_full_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    crc_in_d    = crc_in_q;
    crc_out_d   = crc_out_q;

    // fire matches the cfg_clk_en register: the fabric shifts on this edge.
    fire     = (state_q == LOAD) && (sr_cnt_q != 6'd0);
    accept   = s_ready && s_valid;
    last_bit = fire && (cnt_q == CNT_W'(CHAIN_LEN - 1));
    // Shift register is free for a new word after this edge.
    sr_drain = (sr_cnt_q == 6'd0) || (fire && (sr_cnt_q == 6'd1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          cnt_d       = '0;
          sr_cnt_d    = 6'd0;
          hold_full_d = 1'b0;
          crc_in_d    = 16'hFFFF;
          crc_out_d   = 16'hFFFF;
        end
      end
      LOAD: begin
        if (fire) begin
          cnt_d     = cnt_q + 1'b1;
          sr_d      = {sr_q[1:31], 1'b0};
          sr_cnt_d  = sr_cnt_q - 6'd1;
          crc_in_d  = crc16_step(crc_in_q, sr_q[0]);
          crc_out_d = crc16_step(crc_out_q, ccff_tail);
        end
        // Holding word takes priority; with an empty holder a fresh word
        // bypasses straight into the shift register so output stays gapless.
        if (sr_drain) begin
          if (hold_full_q) begin
            sr_d        = hold_q;
            sr_cnt_d    = 6'd32;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sr_d     = s_data;
            sr_cnt_d = 6'd32;
          end
        end else if (accept) begin
          hold_d      = s_data;
          hold_full_d = 1'b1;
        end
        // Abort wins over completion; leftover bits of the final word are dropped.
        if (abort) begin
          state_d     = IDLE;
          sr_cnt_d    = 6'd0;
          hold_full_d = 1'b0;
        end else if (last_bit) begin
          state_d     = FIN;
          sr_cnt_d    = 6'd0;
          hold_full_d = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept another word only while buffered bits fall short of what remains.
    remaining = (CNT_W+1)'(CHAIN_LEN) - (CNT_W+1)'(cnt_d);
    s_ready_d = (state_d == LOAD) && !hold_full_d && ((CNT_W+1)'(sr_cnt_d) < remaining);
    en_d      = (state_d == LOAD) && (sr_cnt_d != 6'd0);
    head_d    = en_d & sr_d[0];
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
  end

  // Control state and all outputs, asynchronously reset.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_cnt_q    <= 6'd0;
      hold_full_q <= 1'b0;
      crc_in_q    <= 16'hFFFF;
      crc_out_q   <= 16'hFFFF;
      s_ready     <= 1'b0;
      ccff_head   <= 1'b0;
      cfg_clk_en  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_cnt_q    <= sr_cnt_d;
      hold_full_q <= hold_full_d;
      crc_in_q    <= crc_in_d;
      crc_out_q   <= crc_out_d;
      s_ready     <= s_ready_d;
      ccff_head   <= head_d;
      cfg_clk_en  <= en_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Word buffers are pure data; their occupancy flags carry validity.
  always_ff @(posedge prog_clk) begin
    sr_q   <= sr_d;
    hold_q <= hold_d;
  end

  assign crc_in  = crc_in_q;
  assign crc_out = crc_out_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: directed load scenarios with random words, a
// 40-flop fabric chain model and a bit-list reference model for CRCs.
module tb_ccff_chain_loader;
  localparam int CL = 40;

  logic        prog_clk = 1'b0;
  logic        prog_reset, start, abort, s_valid;
  logic [0:31] s_data;
  logic        s_ready, ccff_head, cfg_clk_en, ccff_tail, busy, done;
  logic [0:15] crc_in, crc_out;

  ccff_chain_loader #(.CHAIN_LEN(CL), .CNT_W(16)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .cfg_clk_en(cfg_clk_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .crc_in(crc_in), .crc_out(crc_out));

  always #5 prog_clk = ~prog_clk;

  // Fabric chain: chain[0] is the head flop, chain[CL-1] drives ccff_tail.
  logic [CL-1:0] chain, chain_seed;
  logic          chain_init;
  always @(posedge prog_clk) begin
    if (chain_init) chain <= chain_seed;
    else if (cfg_clk_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:31]   words [0:2];
  logic          exp_bits[$];
  logic          tail_bits[$];
  logic [15:0]   crc_a;
  logic [15:0]   crc_tmp;
  logic [CL-1:0] chain_cont;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-16-CCITT over the first n bits of a bit list.
  function automatic logic [15:0] crc_ref(input logic q[$], input int n);
    int c;
    c = 32'hFFFF;
    for (int i = 0; i < n; i++) begin
      if ((((c >> 15) & 1) ^ int'(q[i])) != 0) c = ((c << 1) ^ 32'h1021) & 32'hFFFF;
      else c = (c << 1) & 32'hFFFF;
    end
    return c[15:0];
  endfunction

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // One load. stall_len: cycles s_valid is held low before word 1.
  // abort_at / reset_at: enabled-edge count that triggers abort / async reset (-1 = never).
  // start_mid: cycle index of a stray start pulse while busy (-1 = never).
  task automatic run_load(input int stall_len, input int exp_gap, input int abort_at,
                          input int start_mid, input int reset_at, output logic [15:0] crc_fin);
    int wi, nen, stalled, first_en, last_en, cyc, gap;
    logic got_done, acc, aborted, stop;
    logic [CL-1:0] exp_chain;
    exp_bits.delete();
    tail_bits.delete();
    for (int i = 0; i < CL; i++) begin
      exp_bits.push_back(words[i / 32][i % 32]);
      tail_bits.push_back(chain[CL-1-i]);
      exp_chain[CL-1-i] = words[i / 32][i % 32];
    end
    wi = 0; nen = 0; stalled = 0; first_en = -1; last_en = -1; cyc = 0;
    got_done = 1'b0; aborted = 1'b0; stop = 1'b0;
    crc_fin = 16'h0;

    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ready_after_start", 64'(s_ready), 64'd1);

    while (!stop && cyc < 400) begin
      if (done) begin
        got_done = 1'b1;
        stop = 1'b1;
      end else begin
        if (cfg_clk_en) begin
          if (nen < CL) chk("head_bit", 64'(ccff_head), 64'(exp_bits[nen]));
          else chk("en_after_last", 64'(cfg_clk_en), 64'd0);
          if (first_en < 0) first_en = cyc;
          last_en = cyc;
          nen++;
        end
        if (reset_at >= 0 && nen == reset_at) begin
          prog_reset = 1'b1;
          #1;
          chk("rst_s_ready", 64'(s_ready), 64'd0);
          chk("rst_head", 64'(ccff_head), 64'd0);
          chk("rst_en", 64'(cfg_clk_en), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_done", 64'(done), 64'd0);
          chk("rst_crc_in", 64'(crc_in), 64'hFFFF);
          chk("rst_crc_out", 64'(crc_out), 64'hFFFF);
          #2;
          prog_reset = 1'b0;
          s_valid = 1'b0;
          return;
        end
        if (wi < 3) begin
          if (wi == 1 && stalled < stall_len) begin
            s_valid = 1'b0;
            stalled++;
          end else begin
            s_valid = 1'b1;
            s_data  = words[wi];
          end
        end else s_valid = 1'b0;
        acc = s_ready && s_valid;
        if (abort_at >= 0 && nen == abort_at) begin
          abort = 1'b1;
          aborted = 1'b1;
        end
        if (cyc == start_mid) start = 1'b1;
        step();
        if (acc) wi++;
        abort = 1'b0;
        start = 1'b0;
        cyc++;
        if (aborted) begin
          s_valid = 1'b0;
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_en", 64'(cfg_clk_en), 64'd0);
          chk("abort_crc_in", 64'(crc_in), 64'(crc_ref(exp_bits, nen)));
          chk("abort_crc_out", 64'(crc_out), 64'(crc_ref(tail_bits, nen)));
          for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", 64'(done), 64'd0);
            step();
          end
          return;
        end
      end
    end
    s_valid = 1'b0;

    chk("done_seen", 64'(got_done), 64'd1);
    chk("busy_in_fin", 64'(busy), 64'd1);
    chk("enabled_edges", 64'(nen), 64'(CL));
    gap = (nen > 0) ? (last_en - first_en + 1 - nen) : -1;
    chk("starve_gap", 64'(gap), 64'(exp_gap));
    chk("words_accepted", 64'(wi), 64'd2);
    chk("chain_contents", 64'(chain), 64'(exp_chain));
    chk("crc_in_final", 64'(crc_in), 64'(crc_ref(exp_bits, CL)));
    chk("crc_out_final", 64'(crc_out), 64'(crc_ref(tail_bits, CL)));
    crc_fin = crc_in;
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_fall", 64'(busy), 64'd0);
    chk("crc_in_stable", 64'(crc_in), 64'(crc_fin));
    chk("en_idle", 64'(cfg_clk_en), 64'd0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 3; i++) words[i] = $urandom;
  endtask

  initial begin
    prog_reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    chain_seed = {8'($urandom), $urandom};
    chain_init = 1'b1;
    step();
    step();
    chain_init = 1'b0;
    prog_reset = 1'b0;
    step();
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    chk("reset_head", 64'(ccff_head), 64'd0);
    chk("reset_en", 64'(cfg_clk_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_crc_in", 64'(crc_in), 64'hFFFF);
    chk("reset_crc_out", 64'(crc_out), 64'hFFFF);

    // Continuous load with the fixed pattern, third word offered but refused.
    words[0] = 32'hA5A5_0F0F;
    words[1] = 32'h0000_00FF;
    words[2] = $urandom;
    run_load(0, 0, -1, -1, -1, crc_tmp);
    chain_cont = chain;
    step();

    // Same words with word 1 late enough to starve the shifter for 5 cycles.
    run_load(36, 5, -1, -1, -1, crc_tmp);
    chk("starve_chain_same", 64'(chain), 64'(chain_cont));
    step();

    // Short stall hidden by double buffering; this load is pattern A.
    rand_words();
    run_load(5, 0, -1, -1, -1, crc_a);
    step();

    // Pattern B reads pattern A back out of the tail.
    rand_words();
    run_load(0, 0, -1, -1, -1, crc_tmp);
    chk("readback_crc", 64'(crc_out), 64'(crc_a));
    step();

    // Abort after 10 enabled edges, then a clean reload with a stray start mid-load.
    rand_words();
    run_load(0, 0, 10, -1, -1, crc_tmp);
    rand_words();
    run_load(0, 0, -1, 15, -1, crc_tmp);
    step();

    // Asynchronous reset at bit 20, then a clean reload.
    rand_words();
    run_load(0, 0, -1, -1, 20, crc_tmp);
    step();
    rand_words();
    run_load(3, 0, -1, -1, -1, crc_tmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
